alu_arbiter: RTL and testbench

Shares the single 16-bit ALU datapath (add/sub/and/or, 4-bit op field) between two requesters. Each requester presents operands and an op through a valid/ready handshake. The arbiter grants one request at a time using round-robin priority, registers the operands onto the ALU inputs, captures the combinational ALU result and returns it on a shared response channel tagged with the requester id. It sits between the instruction-issue logic and the ALU instance, and owns the ALU input pins exclusively.

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for the shared ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_out;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output resp_valid, resp_id, resp_result,
    input  resp_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  resp_valid, resp_id, resp_result,
    output resp_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One operation is in flight at a time: accept (IDLE) -> capture result (EXEC)
// -> hold response until consumed (RESP). last_grant tracks the owner of the
// most recently consumed response so contention alternates between requesters.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input logic          clock,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_grant_r;
  logic             resp_valid_r;
  logic             resp_id_r;
  logic [WIDTH-1:0] resp_result_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [OPW-1:0]   alu_op_r;

  logic             grant_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [1:0]       sel_op_s;
  logic [OPW-1:0]   alu_op_s;
  logic             op_unused_s;

  // Only op[1:0] reaches the ALU; the upper op bits are deliberately ignored.
  assign op_unused_s = ^{bus.req0_op[OPW-1:2], bus.req1_op[OPW-1:2]};

  // Round-robin winner: under contention the requester that did not own the last response wins
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Ready goes only to the winner, only in IDLE, and never while reset is held
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (!reset && (state_r == IDLE)) begin
      bus.req0_ready = bus.req0_valid && !grant_s;
      bus.req1_ready = bus.req1_valid && grant_s;
    end else begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
    end
  end

  // Operand mux for the granted requester; op is narrowed to the two decoded bits
  always_comb begin
    sel_a_s  = bus.req0_a;
    sel_b_s  = bus.req0_b;
    sel_op_s = bus.req0_op[1:0];
    if (grant_s) begin
      sel_a_s  = bus.req1_a;
      sel_b_s  = bus.req1_b;
      sel_op_s = bus.req1_op[1:0];
    end else begin
      sel_a_s  = bus.req0_a;
      sel_b_s  = bus.req0_b;
      sel_op_s = bus.req0_op[1:0];
    end
  end

  assign accept_s = (state_r == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign alu_op_s = {{(OPW-2){1'b0}}, sel_op_s};

  // Control FSM with all datapath and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      last_grant_r  <= 1'b1;
      resp_valid_r  <= 1'b0;
      resp_id_r     <= 1'b0;
      resp_result_r <= {WIDTH{1'b0}};
      alu_a_r       <= {WIDTH{1'b0}};
      alu_b_r       <= {WIDTH{1'b0}};
      alu_op_r      <= {OPW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_a_r   <= sel_a_s;
            alu_b_r   <= sel_b_s;
            alu_op_r  <= alu_op_s;
            resp_id_r <= grant_s;
            state_r   <= EXEC;
          end else begin
            state_r   <= IDLE;
          end
        end
        EXEC: begin
          resp_result_r <= bus.alu_out;
          resp_valid_r  <= 1'b1;
          state_r       <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            last_grant_r <= resp_id_r;
            state_r      <= IDLE;
          end else begin
            state_r      <= RESP;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_id     = resp_id_r;
  assign bus.resp_result = resp_result_r;
  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.alu_op      = alu_op_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model (one outstanding operation,
// its age, and the last consumed owner) predicts every output each cycle, and a
// few directed scenarios pin the model with hand-computed values.
module tb_alu_arbiter;
  localparam int WIDTH = 16;
  localparam int OPW   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [OPW-1:0] op);
    case (op[1:0])
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // External ALU instance modelled combinationally
  assign bus.alu_out = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: at most one outstanding operation
  bit               m_busy;
  int               m_age;
  bit               m_id;
  bit               m_last;
  logic [WIDTH-1:0] m_res;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic [OPW-1:0]   m_op;
  bit               grants[$];
  int               acc_cycle[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_busy = 1'b0; m_age = 0; m_id = 1'b0; m_last = 1'b1;
    m_res = '0; m_a = '0; m_b = '0; m_op = '0;
  endtask

  // Compare every DUT output against what the model says now
  task automatic compare();
    bit v0, v1, e0, e1, ev;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    e0 = !m_busy && v0 && (!v1 || m_last == 1'b1);
    e1 = !m_busy && v1 && (!v0 || m_last == 1'b0);
    ev = m_busy && (m_age >= 1);
    chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
    chk("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
    chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
    chk("alu_a", 32'(bus.alu_a), 32'(m_a));
    chk("alu_b", 32'(bus.alu_b), 32'(m_b));
    chk("alu_op", 32'(bus.alu_op), 32'(m_op));
    if (ev) begin
      chk("resp_id", 32'(bus.resp_id), 32'(m_id));
      chk("resp_result", 32'(bus.resp_result), 32'(m_res));
    end
  endtask

  // Advance the model by one rising edge using the inputs held across it
  task automatic model_edge();
    bit v0, v1, g;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    if (m_busy) begin
      if (m_age == 0) begin
        m_age = 1;
      end else if (bus.resp_ready) begin
        m_last = m_id;
        m_busy = 1'b0;
      end
    end else if (v0 || v1) begin
      g = (v0 && v1) ? !m_last : v1;
      m_a  = g ? bus.req1_a : bus.req0_a;
      m_b  = g ? bus.req1_b : bus.req0_b;
      m_op = {2'b00, (g ? bus.req1_op[1:0] : bus.req0_op[1:0])};
      m_res = alu_fn(m_a, m_b, m_op);
      m_id = g;
      m_busy = 1'b1;
      m_age = 0;
      grants.push_back(g);
      acc_cycle.push_back(cyc);
    end
  endtask

  // One clock: inputs already driven after a falling edge
  task automatic cycle();
    #1;
    compare();
    @(posedge clock);
    model_edge();
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
  endtask

  // Assert reset mid-cycle, check asynchronous clearing, release on a falling edge
  task automatic do_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    #2;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_resp_result", 32'(bus.resp_result), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_hold_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_hold_resp_valid", 32'(bus.resp_valid), 32'd0);
    idle_inputs();
    reset = 1'b0;
    model_clear();
  endtask

  // Issue one operation from a single requester and sample the response in RESP
  task automatic run_op(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [OPW-1:0] op, output logic [WIDTH-1:0] res,
                        output bit rid, output logic [OPW-1:0] aop);
    idle_inputs();
    bus.resp_ready = 1'b1;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
    cycle();
    idle_inputs();
    cycle();
    res = bus.resp_result;
    rid = bus.resp_id;
    aop = bus.alu_op;
    chk("op_resp_valid", 32'(bus.resp_valid), 32'd1);
    cycle();
  endtask

  initial begin
    logic [WIDTH-1:0] res, held_res;
    logic [OPW-1:0]   aop;
    bit               rid, held_id;

    idle_inputs();
    bus.resp_ready = 1'b1;
    model_clear();
    @(negedge clock);
    do_reset();

    // Basic add, wrap cases, upper op bits masked
    run_op(1'b0, 16'h0003, 16'h0004, 4'h0, res, rid, aop);
    chk("add_result", 32'(res), 32'h0007);
    chk("add_id", 32'(rid), 32'd0);
    run_op(1'b1, 16'h0000, 16'h0001, 4'h1, res, rid, aop);
    chk("sub_wrap_result", 32'(res), 32'hFFFF);
    chk("sub_wrap_id", 32'(rid), 32'd1);
    run_op(1'b0, 16'hFFFF, 16'h0001, 4'h0, res, rid, aop);
    chk("add_wrap_result", 32'(res), 32'h0000);
    run_op(1'b0, 16'h00FF, 16'h0F0F, 4'b0110, res, rid, aop);
    chk("masked_op_alu_op", 32'(aop), 32'h2);
    chk("masked_op_result", 32'(res), 32'h000F);

    // Continuous contention after reset: 0,1,0,1 three cycles apart
    do_reset();
    grants.delete();
    acc_cycle.delete();
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 16'hF0F0; bus.req0_b = 16'h0FF0; bus.req0_op = 4'h2;
    bus.req1_valid = 1'b1; bus.req1_a = 16'hF0F0; bus.req1_b = 16'h0FF0; bus.req1_op = 4'h3;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i == 1) chk("and_result", 32'(bus.resp_result), 32'h00F0);
      if (i == 4) chk("or_result", 32'(bus.resp_result), 32'hFFF0);
    end
    chk("rr_count", 32'(grants.size()), 32'd4);
    if (grants.size() >= 4) begin
      chk("rr_g0", 32'(grants[0]), 32'd0);
      chk("rr_g1", 32'(grants[1]), 32'd1);
      chk("rr_g2", 32'(grants[2]), 32'd0);
      chk("rr_g3", 32'(grants[3]), 32'd1);
      chk("rr_spacing", 32'(acc_cycle[3] - acc_cycle[2]), 32'd3);
    end

    // Backpressure: hold RESP for 5 cycles with req1 waiting
    while (m_busy) begin
      idle_inputs();
      cycle();
    end
    idle_inputs();
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h1111; bus.req0_op = 4'h0;
    cycle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0009; bus.req1_b = 16'h0002; bus.req1_op = 4'h1;
    cycle();
    held_res = bus.resp_result;
    held_id  = bus.resp_id;
    chk("bp_result", 32'(held_res), 32'h2345);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_valid_hold", 32'(bus.resp_valid), 32'd1);
      chk("bp_result_hold", 32'(bus.resp_result), 32'(held_res));
      chk("bp_id_hold", 32'(bus.resp_id), 32'(held_id));
      chk("bp_req1_blocked", 32'(bus.req1_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    cycle();
    #1;
    chk("bp_req1_ready_after", 32'(bus.req1_ready), 32'd1);
    cycle();
    bus.req1_valid = 1'b0;
    cycle();
    chk("bp_req1_result", 32'(bus.resp_result), 32'h0007);
    cycle();

    // Reset while in EXEC: no response, then requester 0 wins contention
    idle_inputs();
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0001; bus.req1_b = 16'h0001; bus.req1_op = 4'h0;
    cycle();
    do_reset();
    cycle();
    chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    grants.delete();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0005; bus.req0_b = 16'h0001; bus.req0_op = 4'h1;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0006; bus.req1_b = 16'h0001; bus.req1_op = 4'h1;
    #1;
    chk("post_reset_grant0", 32'(bus.req0_ready), 32'd1);
    cycle();
    idle_inputs();
    cycle();
    chk("post_reset_result", 32'(bus.resp_result), 32'h0004);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req0_a = WIDTH'($urandom); bus.req0_b = WIDTH'($urandom); bus.req0_op = OPW'($urandom);
      bus.req1_a = WIDTH'($urandom); bus.req1_b = WIDTH'($urandom); bus.req1_op = OPW'($urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
